// File: rtl/kbd_pkg.sv
// Shared scan-code constants, prefix FSM states and set-2 to ASCII translation.
package kbd_pkg;

    // Prefix and modifier scan codes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Extended arrow codes (after E0)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // ASCII control characters and arrow key codes
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] KEY_UP      = 8'h80;
    localparam logic [7:0] KEY_DOWN    = 8'h81;
    localparam logic [7:0] KEY_LEFT    = 8'h82;
    localparam logic [7:0] KEY_RIGHT   = 8'h83;

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} prefix_state_e;

    // Lowercase letter for a scan code, 0x00 if the code is not a letter
    function automatic logic [7:0] letter_of(input logic [7:0] code);
        unique case (code)
            8'h1C: letter_of = "a";  8'h32: letter_of = "b";  8'h21: letter_of = "c";
            8'h23: letter_of = "d";  8'h24: letter_of = "e";  8'h2B: letter_of = "f";
            8'h34: letter_of = "g";  8'h33: letter_of = "h";  8'h43: letter_of = "i";
            8'h3B: letter_of = "j";  8'h42: letter_of = "k";  8'h4B: letter_of = "l";
            8'h3A: letter_of = "m";  8'h31: letter_of = "n";  8'h44: letter_of = "o";
            8'h4D: letter_of = "p";  8'h15: letter_of = "q";  8'h2D: letter_of = "r";
            8'h1B: letter_of = "s";  8'h2C: letter_of = "t";  8'h3C: letter_of = "u";
            8'h2A: letter_of = "v";  8'h1D: letter_of = "w";  8'h22: letter_of = "x";
            8'h35: letter_of = "y";  8'h1A: letter_of = "z";
            default: letter_of = 8'h00;
        endcase
    endfunction

    // {unshifted, shifted} glyph for digits/punctuation, 0 if unmapped
    function automatic logic [15:0] symbol_of(input logic [7:0] code);
        unique case (code)
            8'h16: symbol_of = {"1", "!"};   8'h1E: symbol_of = {"2", "@"};
            8'h26: symbol_of = {"3", "#"};   8'h25: symbol_of = {"4", "$"};
            8'h2E: symbol_of = {"5", "%"};   8'h36: symbol_of = {"6", "^"};
            8'h3D: symbol_of = {"7", "&"};   8'h3E: symbol_of = {"8", "*"};
            8'h46: symbol_of = {"9", "("};   8'h45: symbol_of = {"0", ")"};
            8'h0E: symbol_of = {8'h60, "~"}; 8'h4E: symbol_of = {"-", "_"};
            8'h55: symbol_of = {"=", "+"};   8'h54: symbol_of = {"[", "{"};
            8'h5B: symbol_of = {"]", "}"};   8'h5D: symbol_of = {"\\", "|"};
            8'h4C: symbol_of = {";", ":"};   8'h52: symbol_of = {"'", "\""};
            8'h41: symbol_of = {",", "<"};   8'h49: symbol_of = {".", ">"};
            8'h4A: symbol_of = {"/", "?"};
            default: symbol_of = 16'h0000;
        endcase
    endfunction

    // Returns {valid, char}; valid=0 means the code produces nothing
    function automatic logic [8:0] scan2ascii(input logic [7:0] code, input logic shift,
                                              input logic caps, input logic ctrl,
                                              input logic ext);
        logic [7:0]  letter;
        logic [15:0] sym;
        letter     = letter_of(code);
        sym        = symbol_of(code);
        scan2ascii = 9'h000;
        if (ext) begin
            unique case (code)
                SC_UP:    scan2ascii = {1'b1, KEY_UP};
                SC_DOWN:  scan2ascii = {1'b1, KEY_DOWN};
                SC_LEFT:  scan2ascii = {1'b1, KEY_LEFT};
                SC_RIGHT: scan2ascii = {1'b1, KEY_RIGHT};
                default:  scan2ascii = 9'h000;
            endcase
        end else if (letter != 8'h00) begin
            // Ctrl maps a..z onto 0x01..0x1A regardless of case
            if (ctrl)              scan2ascii = {1'b1, letter - 8'h60};
            else if (shift ^ caps) scan2ascii = {1'b1, letter - 8'h20};
            else                   scan2ascii = {1'b1, letter};
        end else if (sym != 16'h0000) begin
            scan2ascii = {1'b1, shift ? sym[7:0] : sym[15:8]};
        end else begin
            unique case (code)
                8'h29:   scan2ascii = {1'b1, ASCII_SPACE};
                8'h5A:   scan2ascii = {1'b1, ASCII_CR};
                8'h66:   scan2ascii = {1'b1, ASCII_BS};
                8'h0D:   scan2ascii = {1'b1, ASCII_TAB};
                8'h76:   scan2ascii = {1'b1, ASCII_ESC};
                default: scan2ascii = 9'h000;
            endcase
        end
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous show-ahead FIFO; head reads 0x00 when empty.
module kbd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // Pointer update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan codes to ASCII: prefix FSM, modifier tracking, character FIFO.
module ps2_ascii_decoder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       ready,
    output logic       overflow,
    output logic [2:0] mods
);
    import kbd_pkg::*;

    prefix_state_e state;
    logic lshift_held, rshift_held, lctrl_held, rctrl_held, caps_held, caps_lock;
    logic shift, ctrl;
    logic is_break, is_ext, is_prefix, key_make;
    logic [8:0] xlat;
    logic push, fifo_full, fifo_empty;

    assign shift = lshift_held | rshift_held;
    assign ctrl  = lctrl_held | rctrl_held;
    assign mods  = {caps_lock, ctrl, shift};

    assign is_break  = (state == StBrk) || (state == StExtBrk);
    assign is_ext    = (state == StExt) || (state == StExtBrk);
    // Bytes that only advance the prefix FSM and are not keys themselves
    assign is_prefix = ((state == StIdle) && (scan_code == SC_BREAK || scan_code == SC_EXT)) ||
                       ((state == StExt) && (scan_code == SC_BREAK));
    assign key_make  = !is_break;

    // Translation uses modifier state held before this byte's edge
    assign xlat = scan2ascii(scan_code, shift, caps_lock, ctrl, is_ext);
    assign push = scan_valid && !is_prefix && key_make && xlat[8];

    // Prefix FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= StIdle;
        end else if (scan_valid) begin
            unique case (state)
                StIdle: begin
                    if (scan_code == SC_BREAK)    state <= StBrk;
                    else if (scan_code == SC_EXT) state <= StExt;
                    else                          state <= StIdle;
                end
                StExt:   state <= (scan_code == SC_BREAK) ? StExtBrk : StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Modifier held flags and caps-lock toggle
    always_ff @(posedge clk) begin
        if (!rst) begin
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            lctrl_held  <= 1'b0;
            rctrl_held  <= 1'b0;
            caps_held   <= 1'b0;
            caps_lock   <= 1'b0;
        end else if (scan_valid && !is_prefix) begin
            if (is_ext) begin
                if (scan_code == SC_CTRL) rctrl_held <= key_make;
            end else begin
                unique case (scan_code)
                    SC_LSHIFT: lshift_held <= key_make;
                    SC_RSHIFT: rshift_held <= key_make;
                    SC_CTRL:   lctrl_held  <= key_make;
                    SC_CAPS: begin
                        // Typematic repeats arrive while held and must not re-toggle
                        if (key_make && !caps_held) caps_lock <= ~caps_lock;
                        caps_held <= key_make;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky overflow: a character was dropped on a full FIFO with no pop
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !rd) begin
            overflow <= 1'b1;
        end
    end

    kbd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd),
        .din   (xlat[7:0]),
        .head  (dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ready = !fifo_empty;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: vector table plus FIFO/reset corner sequences.
module tb_ps2_ascii_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       rd;
    logic [7:0] dout;
    logic       ready;
    logic       overflow;
    logic [2:0] mods;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       sv;
        logic [7:0] code;
        logic       rd;
        logic [7:0] exp_dout;
        logic       exp_ready;
        logic [2:0] exp_mods;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ps2_ascii_decoder #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .rd         (rd),
        .dout       (dout),
        .ready      (ready),
        .overflow   (overflow),
        .mods       (mods)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One clock: inputs applied before the edge, outputs sampled 1 time unit after it
    task automatic cyc(input logic sv, input logic [7:0] code, input logic r);
        scan_valid = sv;
        scan_code  = code;
        rd         = r;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        rd         = 1'b0;
    endtask

    function automatic void add(input logic sv, input logic [7:0] code, input logic r,
                                input logic [7:0] d, input logic rdy, input logic [2:0] m);
        vec_t v;
        v.sv = sv; v.code = code; v.rd = r;
        v.exp_dout = d; v.exp_ready = rdy; v.exp_mods = m;
        vecs.push_back(v);
    endfunction

    logic [7:0] drain_exp [16];
    logic [7:0] fill_codes [16];

    initial begin
        // 'a' make then break, then pop
        add(1, 8'h1C, 0, 8'h61, 1, 3'b000);
        add(1, 8'hF0, 0, 8'h61, 1, 3'b000);
        add(1, 8'h1C, 0, 8'h61, 1, 3'b000);
        add(0, 8'h00, 1, 8'h00, 0, 3'b000);
        // Shift held: 'A' then 'a'
        add(1, 8'h12, 0, 8'h00, 0, 3'b001);
        add(1, 8'h1C, 0, 8'h41, 1, 3'b001);
        add(1, 8'hF0, 0, 8'h41, 1, 3'b001);
        add(1, 8'h1C, 0, 8'h41, 1, 3'b001);
        add(1, 8'hF0, 0, 8'h41, 1, 3'b001);
        add(1, 8'h12, 0, 8'h41, 1, 3'b000);
        add(1, 8'h1C, 0, 8'h41, 1, 3'b000);
        add(0, 8'h00, 1, 8'h61, 1, 3'b000);
        add(0, 8'h00, 1, 8'h00, 0, 3'b000);
        // Caps toggles once despite repeat; shift XOR caps
        add(1, 8'h58, 0, 8'h00, 0, 3'b100);
        add(1, 8'h58, 0, 8'h00, 0, 3'b100);
        add(1, 8'hF0, 0, 8'h00, 0, 3'b100);
        add(1, 8'h58, 0, 8'h00, 0, 3'b100);
        add(1, 8'h1C, 0, 8'h41, 1, 3'b100);
        add(1, 8'h12, 0, 8'h41, 1, 3'b101);
        add(1, 8'h1C, 0, 8'h41, 1, 3'b101);
        add(0, 8'h00, 1, 8'h61, 1, 3'b101);
        add(1, 8'hF0, 0, 8'h61, 1, 3'b101);
        add(1, 8'h12, 1, 8'h00, 0, 3'b100);
        // Digits ignore caps, follow shift; push+pop same cycle
        add(1, 8'h16, 0, 8'h31, 1, 3'b100);
        add(1, 8'h12, 0, 8'h31, 1, 3'b101);
        add(1, 8'h16, 1, 8'h21, 1, 3'b101);
        add(1, 8'hF0, 0, 8'h21, 1, 3'b101);
        add(1, 8'h12, 0, 8'h21, 1, 3'b100);
        add(1, 8'h58, 0, 8'h21, 1, 3'b000);
        add(1, 8'hF0, 0, 8'h21, 1, 3'b000);
        add(1, 8'h58, 1, 8'h00, 0, 3'b000);
        // Extended arrow, extended break, right ctrl + 'c'
        add(1, 8'hE0, 0, 8'h00, 0, 3'b000);
        add(1, 8'h75, 0, 8'h80, 1, 3'b000);
        add(1, 8'hE0, 0, 8'h80, 1, 3'b000);
        add(1, 8'hF0, 0, 8'h80, 1, 3'b000);
        add(1, 8'h75, 0, 8'h80, 1, 3'b000);
        add(1, 8'hE0, 0, 8'h80, 1, 3'b000);
        add(1, 8'h14, 0, 8'h80, 1, 3'b010);
        add(1, 8'h21, 0, 8'h80, 1, 3'b010);
        add(0, 8'h00, 1, 8'h03, 1, 3'b010);
        add(0, 8'h00, 1, 8'h00, 0, 3'b010);
        add(1, 8'hE0, 0, 8'h00, 0, 3'b010);
        add(1, 8'hF0, 0, 8'h00, 0, 3'b010);
        add(1, 8'h14, 0, 8'h00, 0, 3'b000);
        // Specials; non-extended 75 and E0 5A are unmapped
        add(1, 8'h29, 0, 8'h20, 1, 3'b000);
        add(1, 8'h75, 0, 8'h20, 1, 3'b000);
        add(0, 8'h00, 1, 8'h00, 0, 3'b000);
        add(1, 8'hE0, 0, 8'h00, 0, 3'b000);
        add(1, 8'h5A, 0, 8'h00, 0, 3'b000);
        add(1, 8'h5A, 0, 8'h0D, 1, 3'b000);
        add(1, 8'h66, 1, 8'h08, 1, 3'b000);
        add(0, 8'h00, 1, 8'h00, 0, 3'b000);

        fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                       8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};
        for (int i = 0; i < 15; i++) drain_exp[i] = 8'h62 + 8'(i);
        drain_exp[15] = 8'h7A;

        rst = 1'b0; scan_valid = 1'b0; scan_code = 8'h00; rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", dout, 8'h00);
        check("reset_ready", {7'b0, ready}, 8'h00);
        check("reset_overflow", {7'b0, overflow}, 8'h00);
        check("reset_mods", {5'b0, mods}, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].sv, vecs[i].code, vecs[i].rd);
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_ready", i), {7'b0, ready}, {7'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d_mods", i), {5'b0, mods}, {5'b0, vecs[i].exp_mods});
        end
        check("table_overflow", {7'b0, overflow}, 8'h00);

        // Fill to 16 entries, then push+pop while full, then overflow
        for (int i = 0; i < 16; i++) cyc(1'b1, fill_codes[i], 1'b0);
        check("full_head", dout, 8'h61);
        check("full_ready", {7'b0, ready}, 8'h01);
        check("full_overflow", {7'b0, overflow}, 8'h00);
        cyc(1'b1, 8'h1A, 1'b1);
        check("full_pushpop_head", dout, 8'h62);
        check("full_pushpop_overflow", {7'b0, overflow}, 8'h00);
        cyc(1'b1, 8'h15, 1'b0);
        check("overflow_set", {7'b0, overflow}, 8'h01);
        check("overflow_head", dout, 8'h62);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), dout, drain_exp[i]);
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("drained_ready", {7'b0, ready}, 8'h00);
        check("drained_dout", dout, 8'h00);
        check("overflow_sticky", {7'b0, overflow}, 8'h01);

        // Caps on, F0 pending, then reset: prefix and modifiers discarded
        cyc(1'b1, 8'h58, 1'b0);
        check("caps_before_reset", {5'b0, mods}, 8'h04);
        cyc(1'b1, 8'hF0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        check("rst2_mods", {5'b0, mods}, 8'h00);
        check("rst2_overflow", {7'b0, overflow}, 8'h00);
        check("rst2_ready", {7'b0, ready}, 8'h00);
        cyc(1'b1, 8'h1C, 1'b0);
        check("post_rst_char", dout, 8'h61);
        check("post_rst_ready", {7'b0, ready}, 8'h01);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        check("rd_empty_ready", {7'b0, ready}, 8'h00);
        check("rd_empty_dout", dout, 8'h00);
        cyc(1'b1, 8'h32, 1'b0);
        check("after_rd_empty_char", dout, 8'h62);
        cyc(1'b0, 8'h00, 1'b1);
        check("after_rd_empty_ready", {7'b0, ready}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Converts the raw PS/2 set-2 scan-code byte stream from the keyboard receiver into ASCII key events and queues them for the CPU. It tracks modifier state (Shift, Ctrl, Caps Lock) and handles E0 and F0 prefixes. Translated characters go into a show-ahead FIFO. The block sits between the PS/2 receiver and the CPU I/O read mux: `ready` drives the CPU interrupt line, and `dout` is returned on `ioread`.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- AW, 4: log2(DEPTH).

Ports:
- clk  in  1  system clock (50 MHz CPU domain).
- rst  in  1  synchronous reset, active-low; sampled on rising `clk`.
- scan_valid  in  1  one-cycle strobe; `scan_code` holds a new byte.
- scan_code  in  8  received scan-code byte.
- rd  in  1  CPU pop strobe; level sampled each cycle.
- dout  out  8  FIFO head character (show-ahead); 0x00 when empty.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- mods  out  3  {caps_lock, ctrl, shift} current state.

## Operation
- Prefix FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
- IDLE transitions:
  - F0 → BRK; E0 → EXT.
  - Any other byte: process as a make code, stay in IDLE.
- EXT transitions:
  - F0 → EXT_BRK.
  - Any other byte: process as an extended make, → IDLE.
- BRK and EXT_BRK: next byte is processed as a break, → IDLE.
- Modifiers:
  - Shift is the OR of the L-shift (12) and R-shift (59) held flags.
  - Ctrl is the OR of held flags for 14 and E0 14.
  - Caps Lock (58) toggles `caps_lock` on make only when the caps key is not already held, so typematic repeats do not re-toggle. Its break clears the held flag.
  - Modifier makes and breaks enqueue nothing.
- Translation of non-modifier makes; breaks enqueue nothing:
  - Letters: 'a'..'z', uppercase when shift XOR caps_lock.
  - With ctrl held, letters produce 0x01..0x1A, overriding case.
  - Digits and punctuation (US layout): shifted glyph when shift is held; caps_lock has no effect.
  - Space 29→0x20, Enter 5A→0x0D, Backspace 66→0x08, Tab 0D→0x09, Esc 76→0x1B.
  - Extended arrows: E0 75→0x80 (up), E0 72→0x81 (down), E0 6B→0x82 (left), E0 74→0x83 (right).
  - Unmapped codes, and E0 followed by an unmapped code, are dropped silently.
- FIFO:
  - Push when a translated character is produced.
  - Pop on `rd` when non-empty; `rd` when empty is ignored.
  - Push when full without a same-cycle pop: the character is dropped and `overflow` is set.
  - Simultaneous push and pop when full: both happen and `overflow` is not set.
  - `overflow` clears only on reset.
  - Pointers are AW+1 bits wide; full when MSBs differ and the lower bits are equal.

## Timing
- Reset (`rst`=0 at a rising edge):
  - FSM → IDLE.
  - All held flags and `caps_lock` cleared.
  - FIFO empty; `ready`=0, `dout`=0x00, `overflow`=0, `mods`=3'b000.
- Latency: a `scan_valid` at edge n makes the character visible on `dout` with `ready`=1 after edge n. There is one cycle of latency and no intermediate register.
- `mods` updates at the same edge as the scan byte.
- A character translated at edge n uses the modifier state held before edge n.
- `rd` at edge n advances the head. The next entry, or 0x00 with `ready`=0, appears after edge n.
- `dout` is combinational from the RAM read plus the head pointer. It is stable whenever `ready`=1 and no `rd` is in progress.
- Reset mid-sequence (for example after F0) discards the prefix. The next byte is interpreted from IDLE.
- `scan_valid` has no back-pressure. Bytes arriving on consecutive cycles are all processed.

## Structure
- Package `kbd_pkg` holds:
  - Scan-code constants: `SC_BREAK`=F0, `SC_EXT`=E0, shift/ctrl/caps codes, arrow codes.
  - ASCII control constants.
  - The FSM state enum.
  - The translation function `scan2ascii(code, shift, caps, ctrl, ext)`, returning {valid, char}.
- One sub-module: `kbd_fifo` (parameterised DEPTH/AW synchronous show-ahead FIFO with push, pop, full, empty and head outputs).
- The top block contains the prefix FSM, the modifier registers, translation, and overflow logic.

## Test plan
- Reset then send 1C, then F0 1C → one entry 0x61 ('a'), `ready`=1 after one cycle; `rd` → `ready`=0, `dout`=0x00.
- Send 12, 1C, F0 1C, F0 12, 1C → FIFO holds 0x41 then 0x61; `mods`=001 while shift is held.
- Send 58, 58, F0 58, 1C → caps toggles once; produces 0x41. Then 12 1C → 0x61 (shift XOR caps).
- Send E0 75, E0 F0 75, E0 14, 21 → 0x80, then 0x03 (Ctrl+C); `mods`=010 after E0 14.
- Push 17 characters (DEPTH=16) without `rd` → `overflow`=1 and the first 16 are intact. Then push and `rd` in the same cycle while full → count stays 16, head advances.
- Send F0, pulse reset, send 1C → 0x61 enqueued (prefix discarded). `rd` with FIFO empty → no state change.
